// File: rtl/drt_reader_if.sv
// drt_reader_if: Wishbone read port between the DRT walker and the DRT ROM
interface drt_reader_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  modport master (output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, input wbm_dat_i, wbm_ack_i);
  modport slave (input wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, output wbm_dat_i, wbm_ack_i);
endinterface

// File: rtl/drt_reader.sv
// drt_reader: walks the Device ROM Table over Wishbone and returns offset/size of a requested device ID
// Optional ack watchdog enabled by defining DRT_READER_TIMEOUT_EN.
module drt_reader #(
  parameter logic [31:0] DRT_BASE_ADR = 32'h0000_0000,
  parameter int MAX_DEVICES = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] search_id,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        err,
  output logic [31:0] drt_id,
  output logic [31:0] num_devices,
  output logic [7:0]  dev_index,
  output logic [31:0] dev_mem_off,
  output logic [31:0] dev_size,
  drt_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, REL, FIN} state_t;
  typedef enum logic [2:0] {HDR_ID, HDR_NUM, ENT_ID, ENT_OFF, ENT_SIZE} step_t;
  state_t state, state_n;
  step_t step, step_n;
  logic [7:0] idx, idx_n, lim;
  logic [31:0] sid, off;
  logic last, to;
  assign busy = state == REQ || state == REL;
  assign done = state == FIN;
  assign lim = num_devices > 32'(MAX_DEVICES) ? 8'(MAX_DEVICES) : num_devices[7:0];
  assign last = {1'b0, idx} + 9'd1 == {1'b0, lim};
  assign off = step == HDR_ID ? 32'd0 : step == HDR_NUM ? 32'd1 :
               32'd4 + {22'd0, idx, 2'b00} + (step == ENT_OFF ? 32'd2 : step == ENT_SIZE ? 32'd3 : 32'd0);
  assign bus.wbm_cyc_o = busy;
  assign bus.wbm_stb_o = state == REQ;
  assign bus.wbm_we_o = 1'b0;
  assign bus.wbm_dat_o = 32'd0;
  assign bus.wbm_adr_o = busy ? DRT_BASE_ADR + off : 32'd0;
`ifdef DRT_READER_TIMEOUT_EN
  logic [31:0] tcnt;
  assign to = busy && tcnt == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst) tcnt <= '0;
    else if (state_n == REQ && state != REQ) tcnt <= '0;
    else if (busy) tcnt <= tcnt + 32'd1;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
  assign to = 1'b0;
`endif
  always_comb begin
    state_n = state;
    step_n = step;
    idx_n = idx;
    if (to) state_n = FIN;
    else case (state)
      IDLE: if (start) begin
        state_n = REQ;
        step_n = HDR_ID;
        idx_n = '0;
      end
      REQ: if (bus.wbm_ack_i) state_n = REL;
      REL: if (!bus.wbm_ack_i) begin
        state_n = REQ;
        case (step)
          HDR_ID: step_n = HDR_NUM;
          HDR_NUM: if (lim == 8'd0) state_n = FIN; else step_n = ENT_ID;
          ENT_ID: if (found) step_n = ENT_OFF; else if (last) state_n = FIN; else idx_n = idx + 8'd1;
          ENT_OFF: step_n = ENT_SIZE;
          default: state_n = FIN;
        endcase
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step <= HDR_ID;
      idx <= '0;
      sid <= '0;
      found <= 1'b0;
      err <= 1'b0;
      drt_id <= '0;
      num_devices <= '0;
      dev_index <= '0;
      dev_mem_off <= '0;
      dev_size <= '0;
    end else begin
      state <= state_n;
      step <= step_n;
      idx <= idx_n;
      if (state == IDLE && start) begin
        sid <= search_id;
        found <= 1'b0;
        err <= 1'b0;
        drt_id <= '0;
        num_devices <= '0;
        dev_index <= '0;
        dev_mem_off <= '0;
        dev_size <= '0;
      end
      if (to) begin
        err <= 1'b1;
        found <= 1'b0;
      end else if (state == REQ && bus.wbm_ack_i) case (step)
        HDR_ID: drt_id <= bus.wbm_dat_i;
        HDR_NUM: num_devices <= bus.wbm_dat_i;
        ENT_ID: if (bus.wbm_dat_i == sid) begin
          found <= 1'b1;
          dev_index <= idx;
        end
        ENT_OFF: dev_mem_off <= bus.wbm_dat_i;
        default: dev_size <= bus.wbm_dat_i;
      endcase
    end
  end
endmodule

// File: tb/tb_drt_reader.sv
// tb_drt_reader: table-driven DRT scans against a ROM slave model, plus hold/reset/timeout sequences
module tb_drt_reader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] search_id = '0;
  logic busy, done, found, err;
  logic [31:0] drt_id, num_devices, dev_mem_off, dev_size;
  logic [7:0] dev_index;
  drt_reader_if bus ();
  drt_reader dut (
    .clk(clk), .rst(rst), .start(start), .search_id(search_id), .busy(busy), .done(done),
    .found(found), .err(err), .drt_id(drt_id), .num_devices(num_devices), .dev_index(dev_index),
    .dev_mem_off(dev_mem_off), .dev_size(dev_size), .bus(bus)
  );
  always #5 clk = ~clk;
  logic [31:0] rom [256];
  logic [31:0] alog [$];
  int hold = 0, hcnt = 0, viol = 0, done_cnt = 0, checks = 0, errors = 0;
  bit no_ack = 0;
  logic prev_stb = 1'b0;
  always @(posedge clk) begin
    if (bus.wbm_stb_o && !prev_stb && bus.wbm_ack_i === 1'b1) viol++;
    if (bus.wbm_stb_o && !bus.wbm_cyc_o) viol++;
    prev_stb <= bus.wbm_stb_o;
    if (rst) begin
      bus.wbm_ack_i <= 1'b0;
      bus.wbm_dat_i <= '0;
      hcnt <= 0;
    end else if (bus.wbm_stb_o && !bus.wbm_ack_i && !no_ack) begin
      alog.push_back(bus.wbm_adr_o);
      bus.wbm_dat_i <= rom[bus.wbm_adr_o[7:0]];
      bus.wbm_ack_i <= 1'b1;
      hcnt <= 0;
    end else if (!bus.wbm_stb_o && bus.wbm_ack_i) begin
      if (hcnt < hold) hcnt <= hcnt + 1;
      else bus.wbm_ack_i <= 1'b0;
    end
  end
  always @(negedge clk) if (done) done_cnt++;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual %h required %h", n, a, e);
    end
  endtask
  task automatic build_rom(input logic [31:0] num);
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = 32'h0001_0001;
    rom[1] = num;
    for (int i = 0; i < 60; i++) begin
      rom[4 + 4 * i] = i + 1;
      rom[6 + 4 * i] = 100 * (i + 1);
      rom[7 + 4 * i] = 10 * (i + 1);
    end
  endtask
  task automatic run_scan(input logic [31:0] sid, input int mid, output int cyc);
    alog.delete();
    done_cnt = 0;
    viol = 0;
    @(negedge clk);
    start = 1'b1;
    search_id = sid;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = cyc == mid;
      if (cyc == mid) search_id = 32'd1;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    repeat (2) @(negedge clk);
    chk("done_pulses", done_cnt, 32'd1);
  endtask
  typedef struct {
    logic [31:0] num, sid;
    logic        exp_found;
    logic [7:0]  exp_idx;
    logic [31:0] exp_off, exp_size;
    int          exp_reads;
    logic [31:0] exp_last;
  } vec_t;
  vec_t vt [8];
  int c;
  initial begin
    vt[0] = '{32'd2, 32'd2, 1'b1, 8'd1, 32'd200, 32'd20, 6, 32'h0B};
    vt[1] = '{32'd2, 32'd5, 1'b0, 8'd0, 32'd0, 32'd0, 4, 32'h08};
    vt[2] = '{32'd0, 32'd1, 1'b0, 8'd0, 32'd0, 32'd0, 2, 32'h01};
    vt[3] = '{32'd40, 32'd99, 1'b0, 8'd0, 32'd0, 32'd0, 18, 32'h40};
    vt[4] = '{32'd40, 32'd16, 1'b1, 8'd15, 32'd1600, 32'd160, 20, 32'h43};
    vt[5] = '{32'd40, 32'd17, 1'b0, 8'd0, 32'd0, 32'd0, 18, 32'h40};
    vt[6] = '{32'd3, 32'd1, 1'b1, 8'd0, 32'd100, 32'd10, 5, 32'h07};
    vt[7] = '{32'd1, 32'd1, 1'b1, 8'd0, 32'd100, 32'd10, 5, 32'h07};
    build_rom(32'd2);
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_found", {31'd0, found}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_results", drt_id | num_devices | dev_mem_off | dev_size | {24'd0, dev_index}, 0);
    chk("rst_bus", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
    chk("rst_adr", bus.wbm_adr_o, 0);
    rst = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", {31'd0, busy}, 0);
    for (int i = 0; i < 8; i++) begin
      build_rom(vt[i].num);
      run_scan(vt[i].sid, -1, c);
      chk($sformatf("v%0d_found", i), {31'd0, found}, {31'd0, vt[i].exp_found});
      chk($sformatf("v%0d_index", i), {24'd0, dev_index}, {24'd0, vt[i].exp_idx});
      chk($sformatf("v%0d_off", i), dev_mem_off, vt[i].exp_off);
      chk($sformatf("v%0d_size", i), dev_size, vt[i].exp_size);
      chk($sformatf("v%0d_num", i), num_devices, vt[i].num);
      chk($sformatf("v%0d_drt_id", i), drt_id, 32'h0001_0001);
      chk($sformatf("v%0d_err", i), {31'd0, err}, 0);
      chk($sformatf("v%0d_reads", i), alog.size(), vt[i].exp_reads);
      chk($sformatf("v%0d_last_adr", i), alog.size() > 0 ? alog[$] : 32'hFFFF_FFFF, vt[i].exp_last);
      chk($sformatf("v%0d_cycles", i), c, 4 * vt[i].exp_reads);
      chk($sformatf("v%0d_bus_rules", i), viol, 0);
    end
    begin
      logic [31:0] seq [6];
      seq = '{32'h0, 32'h1, 32'h4, 32'h8, 32'hA, 32'hB};
      build_rom(32'd2);
      run_scan(32'd2, -1, c);
      for (int i = 0; i < 6; i++) chk($sformatf("adr_seq%0d", i), i < alog.size() ? alog[i] : 32'hFFFF_FFFF, seq[i]);
    end
    build_rom(32'd3);
    rom[12] = 32'd2;
    run_scan(32'd2, -1, c);
    chk("first_match_index", {24'd0, dev_index}, 32'd1);
    chk("first_match_off", dev_mem_off, 32'd200);
    hold = 3;
    build_rom(32'd2);
    run_scan(32'd2, 10, c);
    chk("hold_bus_rules", viol, 0);
    chk("hold_found", {31'd0, found}, 1);
    chk("hold_index", {24'd0, dev_index}, 32'd1);
    chk("hold_reads", alog.size(), 32'd6);
    chk("hold_cycles", c, 32'd42);
    hold = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    search_id = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_cyc", {31'd0, bus.wbm_cyc_o}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_bus", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, 0);
`ifdef DRT_READER_TIMEOUT_EN
    no_ack = 1;
    build_rom(32'd2);
    run_scan(32'd2, -1, c);
    chk("to_err", {31'd0, err}, 1);
    chk("to_found", {31'd0, found}, 0);
    chk("to_cycles", c, 32'd255);
    chk("to_bus", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
    no_ack = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
